// File: rtl/relobi_demux.sv
// Reliable-OBI demultiplexer: steers one subordinate port to one of NumMgrPorts manager ports.
// Handshakes run on three independently tracked lanes; any lane disagreement raises tmr_err_o.
package relobi_demux_pkg;

  localparam int unsigned AChanWidth = 64;
  localparam int unsigned RChanWidth = 39;

  // The a and r channels are opaque, already ECC-protected payloads.
  typedef struct packed {
    logic [2:0]            req;
    logic [2:0]            rready;
    logic [AChanWidth-1:0] a;
  } relobi_req_t;

  typedef struct packed {
    logic [2:0]            gnt;
    logic [2:0]            rvalid;
    logic [RChanWidth-1:0] r;
  } relobi_rsp_t;

endpackage

module relobi_demux #(
  parameter bit          UseRReady          = 1'b1,
  parameter type         sbr_port_obi_req_t = relobi_demux_pkg::relobi_req_t,
  parameter type         sbr_port_obi_rsp_t = relobi_demux_pkg::relobi_rsp_t,
  parameter type         mgr_port_obi_req_t = sbr_port_obi_req_t,
  parameter type         mgr_port_obi_rsp_t = sbr_port_obi_rsp_t,
  parameter int unsigned NumMgrPorts        = 2,
  parameter int unsigned NumMaxTrans        = 2,
  parameter int unsigned SelWidth           = $clog2(NumMgrPorts),
  parameter int unsigned CntWidth           = $clog2(NumMaxTrans + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic              [2:0][SelWidth-1:0] sbr_port_select_i,
  input  sbr_port_obi_req_t                   sbr_port_req_i,
  output sbr_port_obi_rsp_t                   sbr_port_rsp_o,
  output mgr_port_obi_req_t [NumMgrPorts-1:0] mgr_ports_req_o,
  input  mgr_port_obi_rsp_t [NumMgrPorts-1:0] mgr_ports_rsp_i,
  output logic                                tmr_err_o
);

  if (NumMgrPorts < 2) begin : gen_bad_num_mgr_ports
    $fatal(1, "relobi_demux: NumMgrPorts must be >= 2");
  end
  if (NumMaxTrans < 1) begin : gen_bad_num_max_trans
    $fatal(1, "relobi_demux: NumMaxTrans must be >= 1");
  end

  localparam logic [CntWidth-1:0] MaxCnt    = CntWidth'(NumMaxTrans);
  localparam logic [SelWidth:0]   PortLimit = (SelWidth + 1)'(NumMgrPorts);

  logic [2:0][CntWidth-1:0] cnt_reg, cnt_next;
  logic [2:0][SelWidth-1:0] sel_reg, sel_next;
  logic [2:0]               sel_legal, ok, gnt_lane, rvalid_lane, hs, rdone;
  logic [SelWidth-1:0]      sel_vote;
  logic                     lane_mismatch, illegal_req;
  logic                     tmr_err_reg, tmr_err_next;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_lane
    logic gnt_sel, rvalid_sel;

    // Mux by comparison so a select beyond NumMgrPorts never indexes past the array.
    always_comb begin
      gnt_sel    = 1'b0;
      rvalid_sel = 1'b0;
      for (int unsigned s = 0; s < NumMgrPorts; s++) begin
        if (SelWidth'(s) == sbr_port_select_i[gi]) gnt_sel = mgr_ports_rsp_i[s].gnt[gi];
        if (SelWidth'(s) == sel_reg[gi])           rvalid_sel = mgr_ports_rsp_i[s].rvalid[gi];
      end
    end

    assign sel_legal[gi] = {1'b0, sbr_port_select_i[gi]} < PortLimit;

    // A new target is only accepted once every older response has drained, keeping order.
    assign ok[gi] = !rst_i && sel_legal[gi] && (cnt_reg[gi] != MaxCnt) &&
                    ((cnt_reg[gi] == '0) || (sbr_port_select_i[gi] == sel_reg[gi]));

    assign gnt_lane[gi]    = gnt_sel && ok[gi];
    assign rvalid_lane[gi] = !rst_i && rvalid_sel && (cnt_reg[gi] != '0);
    assign hs[gi]          = sbr_port_req_i.req[gi] && gnt_lane[gi];
    assign rdone[gi]       = rvalid_lane[gi] && (sbr_port_req_i.rready[gi] || !UseRReady);

    assign cnt_next[gi] = (hs[gi] && !rdone[gi]) ? cnt_reg[gi] + CntWidth'(1) :
                          (!hs[gi] && rdone[gi]) ? cnt_reg[gi] - CntWidth'(1) :
                                                   cnt_reg[gi];
    assign sel_next[gi] = hs[gi] ? sbr_port_select_i[gi] : sel_reg[gi];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg     <= '0;
      sel_reg     <= '0;
      tmr_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      tmr_err_reg <= tmr_err_next;
    end
  end

  // The single r copy follows the 2-of-3 majority of the lane selects.
  always_comb begin
    sel_vote = sel_reg[0];
    if ((sel_reg[1] == sel_reg[2]) && (sel_reg[0] != sel_reg[1])) sel_vote = sel_reg[1];
  end

  always_comb begin
    sbr_port_rsp_o        = '0;
    sbr_port_rsp_o.gnt    = gnt_lane;
    sbr_port_rsp_o.rvalid = rvalid_lane;
    sbr_port_rsp_o.r      = mgr_ports_rsp_i[0].r;
    for (int unsigned s = 0; s < NumMgrPorts; s++) begin
      if (SelWidth'(s) == sel_vote) sbr_port_rsp_o.r = mgr_ports_rsp_i[s].r;
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < NumMgrPorts; s++) begin
      mgr_ports_req_o[s]        = sbr_port_req_i;
      mgr_ports_req_o[s].req    = '0;
      mgr_ports_req_o[s].rready = '0;
      for (int unsigned l = 0; l < 3; l++) begin
        if (SelWidth'(s) == sbr_port_select_i[l]) begin
          mgr_ports_req_o[s].req[l] = sbr_port_req_i.req[l] && ok[l];
        end
        if (SelWidth'(s) == sel_reg[l]) begin
          mgr_ports_req_o[s].rready[l] = !rst_i && (UseRReady ? sbr_port_req_i.rready[l] : 1'b1);
        end
      end
    end
  end

  assign lane_mismatch = (cnt_reg[0] != cnt_reg[1]) || (cnt_reg[0] != cnt_reg[2]) ||
                         (sel_reg[0] != sel_reg[1]) || (sel_reg[0] != sel_reg[2]);
  assign illegal_req   = |(sbr_port_req_i.req & ~sel_legal);
  assign tmr_err_next  = lane_mismatch || illegal_req;
  assign tmr_err_o     = tmr_err_reg;

endmodule
